// File: rtl/lock_timing_pkg.sv
// Shared timing constants and channel state type for the lock controller's
// timer scheduler.
//   CLK_HZ          system clock frequency
//   *_TICKS         default channel loads, in base ticks (1 s per tick at
//                   PRESCALE = CLK_HZ)
//   CH_*            channel index assignment on the scheduler
//   ch_state_t      per-channel IDLE/RUN state
package lock_timing_pkg;

    localparam int CLK_HZ        = 50_000_000;

    localparam int LOCKOUT_TICKS = 30;
    localparam int RELOCK_TICKS  = 10;
    localparam int BLINK_TICKS   = 1;

    localparam int CH_LOCKOUT    = 0;
    localparam int CH_RELOCK     = 1;
    localparam int CH_BLINK      = 2;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: IDLE/RUN FSM with remaining-count, reload value
// and one-shot/periodic mode.
//   clk, rst   clock, asynchronous active-high reset
//   start      load/start strobe (highest priority)
//   stop       cancel strobe
//   periodic   mode captured with start (1 = auto-reload)
//   load       count captured with start
//   tick_int   shared base tick from the prescaler
//   busy       channel is counting
//   expire     one-cycle registered pulse when the count reaches zero
module timer_channel
    import lock_timing_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          periodic,
    input  logic [CW-1:0] load,
    input  logic          tick_int,
    output logic          busy,
    output logic          expire
);

    ch_state_t     state, state_n;
    logic [CW-1:0] rem, rem_n;
    logic [CW-1:0] reload, reload_n;
    logic          mode, mode_n;
    logic          expire_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= CH_IDLE;
            rem    <= '0;
            reload <= '0;
            mode   <= 1'b0;
            expire <= 1'b0;
        end else begin
            state  <= state_n;
            rem    <= rem_n;
            reload <= reload_n;
            mode   <= mode_n;
            expire <= expire_n;
        end
    end

    always_comb begin
        state_n  = state;
        rem_n    = rem;
        reload_n = reload;
        mode_n   = mode;
        expire_n = 1'b0;
        if (start) begin
            // start wins over stop and tick, in either state
            if (load != '0) begin
                state_n  = CH_RUN;
                rem_n    = load;
                reload_n = load;
                mode_n   = periodic;
            end else begin
                // zero load expires immediately without waiting for a tick
                state_n  = CH_IDLE;
                rem_n    = '0;
                expire_n = 1'b1;
            end
        end else if (state == CH_RUN) begin
            if (stop) begin
                // cancel suppresses an expire that would land on this edge
                state_n = CH_IDLE;
                rem_n   = '0;
            end else if (tick_int) begin
                if (rem > CW'(1)) begin
                    rem_n = rem - CW'(1);
                end else if (mode) begin
                    rem_n    = reload;
                    expire_n = 1'b1;
                end else begin
                    state_n  = CH_IDLE;
                    rem_n    = '0;
                    expire_n = 1'b1;
                end
            end
        end
    end

    assign busy = (state == CH_RUN);

endmodule

// File: rtl/tick_timer_sched.sv
// Shares one base-rate prescaler among N_CH independent countdown channels.
// The prescaler only runs while some channel is busy and is held at zero
// otherwise, so a start from all-idle has a deterministic first tick.
//   clk, rst   clock, asynchronous active-high reset
//   start      per-channel load/start strobe
//   stop       per-channel cancel strobe
//   periodic   per-channel mode, captured with start
//   load_val   channel i count at load_val[i*CW +: CW]
//   busy       per-channel counting flag
//   expire     per-channel one-cycle expire pulse
//   tick       registered base tick pulse (only while any channel busy)
module tick_timer_sched #(
    parameter int PRESCALE = 50_000_000,
    parameter int N_CH     = 4,
    parameter int CW       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    start,
    input  logic [N_CH-1:0]    stop,
    input  logic [N_CH-1:0]    periodic,
    input  logic [N_CH*CW-1:0] load_val,
    output logic [N_CH-1:0]    busy,
    output logic [N_CH-1:0]    expire,
    output logic               tick
);

    localparam int            PW      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;
    logic          any_busy;
    logic          tick_int;

    assign any_busy = |busy;
    assign tick_int = any_busy && (pre_cnt == PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= tick_int;
            if (!any_busy || pre_cnt == PRE_MAX)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + PW'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timer_channel #(.CW(CW)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .start    (start[i]),
            .stop     (stop[i]),
            .periodic (periodic[i]),
            .load     (load_val[i*CW +: CW]),
            .tick_int (tick_int),
            .busy     (busy[i]),
            .expire   (expire[i])
        );
    end

endmodule

// File: tb/tb_tick_timer_sched.sv
// Directed bench for tick_timer_sched with PRESCALE=4, N_CH=2, CW=8.
// Edge numbers in comments count from the edge that samples the start.
module tb_tick_timer_sched;

    localparam int PRESCALE = 4;
    localparam int N_CH     = 2;
    localparam int CW       = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start = '0, stop = '0, periodic = '0;
    logic [15:0] load_val = '0;
    logic [1:0]  busy, expire;
    logic        tick;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tick_timer_sched #(.PRESCALE(PRESCALE), .N_CH(N_CH), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .load_val (load_val),
        .busy     (busy),
        .expire   (expire),
        .tick     (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_exp", expire, 0);
        chk("rst_tick", tick, 0);
        rst = 1'b0;
        step();

        // ch0 one-shot L=3 from idle: expire after edge 12, ticks after 4/8/12
        start = 2'b01; periodic = 2'b00; load_val = {8'd0, 8'd3};
        step();
        start = '0;
        chk("t2_busy0", busy, 2'b01);
        for (int e = 1; e <= 13; e++) begin
            step();
            chk("t2_busy", busy, {1'b0, e < 12});
            chk("t2_exp", expire, {1'b0, e == 12});
            chk("t2_tick", tick, (e == 4 || e == 8 || e == 12));
        end

        // ch1 periodic L=2: expire every 8 cycles, then stop
        start = 2'b10; periodic = 2'b10; load_val = {8'd2, 8'd0};
        step();
        start = '0; periodic = '0;
        chk("t3_busy0", busy, 2'b10);
        for (int e = 1; e <= 24; e++) begin
            step();
            chk("t3_busy", busy, 2'b10);
            chk("t3_exp", expire, {(e % 8) == 0, 1'b0});
        end
        stop = 2'b10;
        step();
        stop = '0;
        chk("t3_stop_busy", busy, 0);
        chk("t3_stop_exp", expire, 0);
        chk("t3_stop_tick", tick, 0);
        for (int e = 0; e < 10; e++) begin
            step();
            chk("t3_idle_exp", expire, 0);
            chk("t3_idle_tick", tick, 0);
        end

        // stop on the expiring edge suppresses expire
        start = 2'b01; load_val = {8'd0, 8'd1};
        step();
        start = '0;
        step(); step(); step();
        stop = 2'b01;
        step();                                  // edge 4: rem==1 and tick_int
        stop = '0;
        chk("t4a_busy", busy, 0);
        chk("t4a_exp", expire, 0);
        step();
        chk("t4a_exp_late", expire, 0);
        chk("t4a_tick", tick, 0);

        // start + stop on the expiring edge restarts with L=2, no expire
        start = 2'b01; load_val = {8'd0, 8'd1};
        step();
        start = '0;
        step(); step(); step();
        start = 2'b01; stop = 2'b01; load_val = {8'd0, 8'd2};
        step();                                  // edge 4
        start = '0; stop = '0;
        chk("t4b_busy", busy, 2'b01);
        chk("t4b_exp", expire, 0);
        for (int e = 5; e <= 12; e++) begin
            step();
            chk("t4b_exp_run", expire, {1'b0, e == 12});
            chk("t4b_busy_run", busy, {1'b0, e < 12});
        end
        step();

        // zero load: immediate expire, never busy, prescaler never ticks
        start = 2'b01; load_val = '0;
        step();
        start = '0;
        chk("t5_exp", expire, 2'b01);
        chk("t5_busy", busy, 0);
        for (int e = 0; e < 6; e++) begin
            step();
            chk("t5_exp_after", expire, 0);
            chk("t5_busy_after", busy, 0);
            chk("t5_tick", tick, 0);
        end

        // ch0 L=3 one-shot; ch1 periodic L=1 joins with pre_cnt=2 after its start
        start = 2'b01; periodic = 2'b00; load_val = {8'd0, 8'd3};
        step();                                  // edge 0
        start = '0;
        step();                                  // edge 1
        start = 2'b10; periodic = 2'b10; load_val = {8'd1, 8'd0};
        step();                                  // edge 2
        start = '0; periodic = '0;
        for (int e = 3; e <= 12; e++) begin
            step();
            chk("t6_exp", expire, {(e % 4) == 0, e == 12});
            chk("t6_busy", busy, {1'b1, e < 12});
        end
        stop = 2'b10;
        step();
        stop = '0;
        chk("t6_stop_busy", busy, 0);
        chk("t6_stop_exp", expire, 0);
        chk("t6_stop_tick", tick, 0);
        step();

        // reset mid-run clears everything at once
        start = 2'b01; load_val = {8'd0, 8'd3};
        step();
        start = '0;
        step(); step(); step(); step();          // edge 4
        chk("t1_tick_pre", tick, 1);
        chk("t1_busy_pre", busy, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("t1_busy", busy, 0);
        chk("t1_exp", expire, 0);
        chk("t1_tick", tick, 0);
        step();
        rst = 1'b0;
        for (int e = 0; e < 14; e++) begin
            step();
            chk("t1_exp_after", expire, 0);
            chk("t1_busy_after", busy, 0);
            chk("t1_tick_after", tick, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
